// File: rtl/mem_byte_ctl_pkg.sv
// Shared constants for the memory access sequencer: op codes, FSM states
// and big-endian byte lane positions.
package mem_byte_ctl_pkg;

    typedef enum logic [1:0] {
        OP_LW  = 2'd0,
        OP_SW  = 2'd1,
        OP_LBU = 2'd2,
        OP_SB  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Bit position of the least significant bit of each byte offset.
    // Offset 0 is the most significant byte (big-endian).
    localparam int BYTE_LANE_0 = 24;
    localparam int BYTE_LANE_1 = 16;
    localparam int BYTE_LANE_2 = 8;
    localparam int BYTE_LANE_3 = 0;

    localparam int WORD_W = 32;

endpackage

// File: rtl/mem_byte_ctl_byte_lane_mux.sv
// Combinational byte lane helper: extracts the addressed byte from a word
// and builds the word with the addressed byte replaced.
module byte_lane_mux
    import mem_byte_ctl_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [7:0]        byte_i,
    input  logic [1:0]        off_i,
    output logic [7:0]        byte_o,
    output logic [WORD_W-1:0] word_o
);

    // Insert: physical lane gi (bits gi*8 up) holds byte offset 3-gi.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_o[gi*8 +: 8] = (off_i == 2'(3 - gi)) ? byte_i : word_i[gi*8 +: 8];
        end
    endgenerate

    // Extract the byte selected by the offset.
    always_comb begin
        byte_o = word_i[BYTE_LANE_0 +: 8];
        case (off_i)
            2'd0:    byte_o = word_i[BYTE_LANE_0 +: 8];
            2'd1:    byte_o = word_i[BYTE_LANE_1 +: 8];
            2'd2:    byte_o = word_i[BYTE_LANE_2 +: 8];
            default: byte_o = word_i[BYTE_LANE_3 +: 8];
        endcase
    end

endmodule

// File: rtl/mem_byte_ctl.sv
// Multi-cycle LW/SW/LBU/SB sequencer between the CPU memory stage and a
// word-wide bus. Byte stores are read-modify-write; the CPU is stalled
// while a bus access is in flight.
module mem_byte_ctl
    import mem_byte_ctl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [1:0]  lbu_byte,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_e      state_q;
    op_e         op_q;
    logic [1:0]  off_q;
    logic        mis_q;
    logic [31:0] wdata_q;
    logic [31:0] cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic [7:0]  lane_byte;
    logic [31:0] merged_word;
    logic        timeout_hit;

    // Lane logic works directly on the bus data so the merged store word is
    // ready at the moment the read is acknowledged.
    byte_lane_mux u_lane_mux (
        .word_i (mem_rdata),
        .byte_i (wdata_q[7:0]),
        .off_i  (off_q),
        .byte_o (lane_byte),
        .word_o (merged_word)
    );

    // A zero TIMEOUT never fires; otherwise the last allowed wait cycle is TIMEOUT-1.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

    // Sequencer FSM with registered data outputs and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LW;
            off_q       <= 2'd0;
            mis_q       <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (req) begin
                        op_q        <= op_e'(op);
                        off_q       <= lbu_byte;
                        mis_q       <= (op_e'(op) == OP_LW || op_e'(op) == OP_SW) && (addr[1:0] != 2'd0);
                        wdata_q     <= wdata;
                        mem_addr_q  <= {addr[31:2], 2'b00};
                        mem_wdata_q <= wdata;
                        state_q     <= (op_e'(op) == OP_SW) ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (mem_ack) begin
                        cnt_q <= '0;
                        case (op_q)
                            OP_LW: begin
                                rdata_q <= mem_rdata;
                                err_q   <= mis_q;
                                state_q <= ST_DONE;
                            end
                            OP_LBU: begin
                                rdata_q <= {24'b0, lane_byte};
                                state_q <= ST_DONE;
                            end
                            OP_SB: begin
                                mem_wdata_q <= merged_word;
                                state_q     <= ST_WRITE;
                            end
                            default: begin
                                rdata_q <= '0;
                                state_q <= ST_DONE;
                            end
                        endcase
                    end else if (timeout_hit) begin
                        cnt_q   <= '0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        cnt_q   <= '0;
                        rdata_q <= '0;
                        err_q   <= mis_q;
                        state_q <= ST_DONE;
                    end else if (timeout_hit) begin
                        cnt_q   <= '0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign mem_we    = (state_q == ST_WRITE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall     = mem_req || ((state_q == ST_IDLE) && req);

endmodule

// File: doc/mem_byte_ctl.md
# mem_byte_ctl

Multi-cycle memory access sequencer between the PLP CPU's memory stage and a word-wide memory bus. It executes LW, SW, LBU and SB. Sub-word stores are done as read-modify-write, and LBU results are zero-extended. The byte offset comes from the immediate unit's `lbu_byte` output (address bits [1:0]). The CPU is stalled while an access is in flight.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles to wait for `mem_ack` in any bus state. 0 disables the timeout.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  1  CPU access request, sampled in IDLE.
- `op`  in  2  access type: `OP_LW`=0, `OP_SW`=1, `OP_LBU`=2, `OP_SB`=3.
- `addr`  in  32  byte address.
- `lbu_byte`  in  2  byte offset, equal to addr[1:0].
- `wdata`  in  32  store data. SB uses wdata[7:0].
- `rdata`  out  32  load result, valid while `done`=1.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse with `done`: misaligned word access or timeout.
- `stall`  out  1  CPU pipeline hold.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write enable.
- `mem_addr`  out  32  word-aligned address, {addr[31:2],2'b00}.
- `mem_wdata`  out  32  bus write data.
- `mem_rdata`  in  32  bus read data, valid when `mem_ack`=1.
- `mem_ack`  in  1  bus acknowledge.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - When `req`=1, capture op, addr, lbu_byte and wdata into registers.
  - LW, LBU, SB go to READ. SW goes to WRITE.
- READ:
  - `mem_req`=1, `mem_we`=0.
  - On `mem_ack`, latch `mem_rdata` into the word buffer.
  - LW and LBU go to DONE. SB goes to WRITE.
- WRITE:
  - `mem_req`=1, `mem_we`=1.
  - SW drives captured wdata.
  - SB drives the word buffer with one lane replaced by wdata[7:0].
  - On `mem_ack`, go to DONE.
- DONE: `done`=1, `rdata` driven, next state IDLE.
- Byte lanes are big-endian: offset 0 is [31:24], 1 is [23:16], 2 is [15:8], 3 is [7:0].
- LBU: rdata = {24'b0, selected lane}. LW: rdata = word buffer. SW/SB: rdata = 0.
- Misaligned LW/SW (addr[1:0]≠0): the access is performed at the aligned address and `err`=1 in DONE.
- Timeout:
  - The wait counter clears on every state entry and counts while in READ or WRITE without `mem_ack`.
  - On reaching TIMEOUT: `err`=1, go to DONE, and for SB skip WRITE. Memory is unmodified and rdata=0.
- `stall` = (state≠IDLE && state≠DONE) || (state==IDLE && req).
- `req` in any non-IDLE state is ignored. The CPU holds its inputs while stalled.
- A `mem_ack` seen in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `done`, `err` at 0; `rdata`, `mem_addr`, `mem_wdata` at 0; counter 0.
- Reset mid-access: all outputs go to reset values immediately, without waiting for a clock, and `mem_req` drops. An in-flight SB may leave memory unmodified. It never leaves a partial byte.
- Outputs are registered or decoded from state only. There is no combinational path from `mem_ack` to `mem_req`.
- Minimum latency from `req` cycle to `done` cycle, with `mem_ack` in the first bus cycle:
  - LW, LBU, SW: 2 cycles.
  - SB: 3 cycles.
- Each extra ack-wait cycle adds 1 cycle.
- Back-to-back: a new `req` is accepted in the cycle after DONE, and not in DONE itself.

## Structure
- `OP_*` codes, FSM state encodings and `BYTE_LANE_*` constants go in the shared constant_params include.
- One sub-module, `byte_lane_mux`:
  - Combinational.
  - Performs the lane extract (for LBU) and the lane insert (for SB), given a word, a byte and the offset.

## Test plan
- LW addr=0x100, mem_rdata=0xDEADBEEF, ack on the 1st READ cycle: `done` 2 cycles after req, rdata=0xDEADBEEF, err=0.
- LBU addr=0x102, mem_rdata=0x11223344: rdata=0x00000033, mem_addr=0x100.
- SB addr=0x103, wdata=0xAA, mem_rdata=0x11223344: WRITE drives mem_wdata=0x112233AA with mem_we=1; `done` 3 cycles after req.
- SW addr=0x101: mem_addr=0x100, write performed, `err`=1 with `done`.
- TIMEOUT=4, LW with no ack: after 4 READ cycles, `done`=1, err=1, rdata=0; then a normal LW succeeds.
- Assert `rst` during SB in READ: mem_req=0 immediately, state IDLE, no write occurs after `rst` is released.
